// File: rtl/rle_run_expander_if.sv
// Token-in / pixel-out handshake bundle for the RLE run expander.
// Error pulses travel with the pixel side because downstream consumes them.
interface rle_run_expander_if #(
    parameter int LEN_W = 10
);
    logic             tok_valid;
    logic             tok_ready;
    logic             tok_pixel;
    logic [LEN_W-1:0] tok_len;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_out;
    logic             pix_eol;
    logic             pix_eof;
    logic             err_zero_len;
    logic             err_overrun;

    modport master (
        output tok_valid, tok_pixel, tok_len, pix_ready,
        input  tok_ready, pix_valid, pix_out, pix_eol, pix_eof,
        input  err_zero_len, err_overrun
    );

    modport slave (
        input  tok_valid, tok_pixel, tok_len, pix_ready,
        output tok_ready, pix_valid, pix_out, pix_eol, pix_eof,
        output err_zero_len, err_overrun
    );
endinterface

// File: rtl/rle_run_expander.sv
// Expands {pixel, run length} tokens into a 1-bit pixel stream with
// raster position tracking, line/frame markers and error pulses.
module rle_run_expander #(
    parameter int LEN_W = 10,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic                 new_im,
    rle_run_expander_if.slave    bus
);
    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_remaining, w_remaining_nxt;
    logic [X_W-1:0]   r_x, w_x_nxt;
    logic [Y_W-1:0]   r_y, w_y_nxt;
    logic             r_pix, w_pix_nxt;
    logic             r_err_zero;
    logic             r_err_ovr;

    logic w_pix_valid;
    logic w_eol;
    logic w_eof;
    logic w_xfer;
    logic w_trunc;
    logic w_tok_ready;
    logic w_accept;
    logic w_zero;
    logic w_load;

    always_comb begin
        w_pix_valid = (r_state == RUN);
        w_eol       = w_pix_valid && (r_x == X_LAST);
        w_eof       = w_eol && (r_y == Y_LAST);
        // new_im wins over everything: the pixel on the bus this cycle is not counted
        w_xfer      = w_pix_valid && bus.pix_ready && !new_im;
        w_trunc     = w_xfer && w_eof && (r_remaining > LEN_ONE);

        w_tok_ready = 1'b0;
        if (reset_n && !new_im) begin
            case (r_state)
                IDLE:    w_tok_ready = 1'b1;
                RUN:     w_tok_ready = (r_remaining == LEN_ONE) && bus.pix_ready;
                default: w_tok_ready = 1'b0;
            endcase
        end

        w_accept = bus.tok_valid && w_tok_ready;
        w_zero   = w_accept && (bus.tok_len == '0);
        w_load   = w_accept && (bus.tok_len != '0);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_pix_nxt       = r_pix;

        if (new_im) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = '0;
            w_x_nxt         = '0;
            w_y_nxt         = '0;
        end else begin
            if (w_xfer) begin
                if (r_x == X_LAST) begin
                    w_x_nxt = '0;
                    w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                end else begin
                    w_x_nxt = r_x + 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        w_state_nxt     = RUN;
                        w_remaining_nxt = bus.tok_len;
                        w_pix_nxt       = bus.tok_pixel;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        if (w_trunc) begin
                            w_state_nxt     = IDLE;
                            w_remaining_nxt = '0;
                        end else if (r_remaining == LEN_ONE) begin
                            // A token taken on the last pixel chains with no bubble
                            if (w_load) begin
                                w_remaining_nxt = bus.tok_len;
                                w_pix_nxt       = bus.tok_pixel;
                            end else begin
                                w_state_nxt     = IDLE;
                                w_remaining_nxt = '0;
                            end
                        end else begin
                            w_remaining_nxt = r_remaining - LEN_ONE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_pix       <= 1'b0;
            r_err_zero  <= 1'b0;
            r_err_ovr   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_pix       <= w_pix_nxt;
            r_err_zero  <= w_zero;
            r_err_ovr   <= w_trunc;
        end
    end

    assign bus.tok_ready    = w_tok_ready;
    assign bus.pix_valid    = w_pix_valid;
    assign bus.pix_out      = r_pix;
    assign bus.pix_eol      = w_eol;
    assign bus.pix_eof      = w_eof;
    assign bus.err_zero_len = r_err_zero;
    assign bus.err_overrun  = r_err_ovr;
endmodule

// File: tb/tb_rle_run_expander.sv
// Directed bench for rle_run_expander; frame height is shortened so the
// end-of-frame case is reachable in a few thousand cycles.
module tb_rle_run_expander;
    localparam int LEN_W = 10;
    localparam int IMG_W = 640;
    localparam int IMG_H = 4;

    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    logic new_im = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rle_run_expander_if #(.LEN_W(LEN_W)) bus ();

    rle_run_expander #(
        .LEN_W(LEN_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .CLK    (CLK),
        .reset_n(reset_n),
        .new_im (new_im),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_new_im();
        new_im = 1'b1;
        #1;
        checks++;
        if (bus.tok_ready !== 1'b0) begin
            errors++;
            $display("FAIL new_im_tok_ready: got %0d expected 0", bus.tok_ready);
        end
        tick();
        new_im = 1'b0;
    endtask

    task automatic run_token(input logic pix, input int len, output int n_xfer,
                             output int n_eol, output int eol_idx, output int n_eof,
                             output int n_badpix);
        n_xfer = 0; n_eol = 0; eol_idx = -1; n_eof = 0; n_badpix = 0;
        bus.tok_pixel = pix;
        bus.tok_len   = LEN_W'(len);
        bus.tok_valid = 1'b1;
        bus.pix_ready = 1'b1;
        #1;
        tick();
        bus.tok_valid = 1'b0;
        for (int c = 0; c < len + 8; c++) begin
            #1;
            if (bus.pix_valid !== 1'b1) break;
            n_xfer++;
            if (bus.pix_out !== pix) n_badpix++;
            if (bus.pix_eol === 1'b1) begin
                n_eol++;
                eol_idx = n_xfer;
            end
            if (bus.pix_eof === 1'b1) n_eof++;
            tick();
        end
    endtask

    task automatic test_reset();
        bus.tok_valid = 1'b0; bus.tok_pixel = 1'b0; bus.tok_len = '0;
        bus.pix_ready = 1'b0; new_im = 1'b0; reset_n = 1'b0;
        #12;
        checks++;
        if (bus.pix_valid !== 1'b0) begin
            errors++; $display("FAIL reset_pix_valid: got %0d expected 0", bus.pix_valid);
        end
        checks++;
        if (bus.tok_ready !== 1'b0) begin
            errors++; $display("FAIL reset_tok_ready: got %0d expected 0", bus.tok_ready);
        end
        checks++;
        if (bus.pix_out !== 1'b0 || bus.err_zero_len !== 1'b0 || bus.err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got pix_out=%0d ezl=%0d eov=%0d expected 0,0,0",
                     bus.pix_out, bus.err_zero_len, bus.err_overrun);
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.tok_ready !== 1'b1) begin
            errors++; $display("FAIL idle_tok_ready: got %0d expected 1", bus.tok_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_pix [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_rdy [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.tok_pixel = 1'b1; bus.tok_len = 10'd3; bus.tok_valid = 1'b1; bus.pix_ready = 1'b1;
        #1;
        tick();
        bus.tok_pixel = 1'b0; bus.tok_len = 10'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.pix_valid !== 1'b1 || bus.pix_out !== exp_pix[i]) begin
                errors++;
                $display("FAIL b2b_pix[%0d]: got valid=%0d pix=%0d expected valid=1 pix=%0d",
                         i, bus.pix_valid, bus.pix_out, exp_pix[i]);
            end
            checks++;
            if (bus.tok_ready !== exp_rdy[i]) begin
                errors++;
                $display("FAIL b2b_tok_ready[%0d]: got %0d expected %0d", i, bus.tok_ready, exp_rdy[i]);
            end
            tick();
            if (i == 2) bus.tok_valid = 1'b0;
        end
        #1;
        checks++;
        if (bus.pix_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got pix_valid=%0d expected 0", bus.pix_valid);
        end
    endtask

    task automatic test_stall();
        logic rdy_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int rem = 5;
        int xfers = 0;
        bus.tok_pixel = 1'b1; bus.tok_len = 10'd5; bus.tok_valid = 1'b1; bus.pix_ready = 1'b0;
        #1;
        tick();
        bus.tok_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.pix_ready = rdy_seq[i];
            #1;
            checks++;
            if (bus.pix_valid !== 1'b1 || bus.pix_out !== 1'b1) begin
                errors++;
                $display("FAIL stall_pix[%0d]: got valid=%0d pix=%0d expected 1,1",
                         i, bus.pix_valid, bus.pix_out);
            end
            checks++;
            if (bus.tok_ready !== logic'(rem == 1 && rdy_seq[i])) begin
                errors++;
                $display("FAIL stall_tok_ready[%0d]: got %0d expected %0d",
                         i, bus.tok_ready, (rem == 1 && rdy_seq[i]));
            end
            checks++;
            if (int'(dut.r_remaining) !== rem) begin
                errors++;
                $display("FAIL stall_remaining[%0d]: got %0d expected %0d", i, dut.r_remaining, rem);
            end
            if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) xfers++;
            if (rdy_seq[i]) rem--;
            tick();
        end
        #1;
        checks++;
        if (bus.pix_valid !== 1'b0 || xfers !== 5) begin
            errors++;
            $display("FAIL stall_end: got valid=%0d xfers=%0d expected valid=0 xfers=5",
                     bus.pix_valid, xfers);
        end
    endtask

    task automatic test_line_wrap();
        int n, ne, ei, nf, nb;
        pulse_new_im();
        run_token(1'b0, 641, n, ne, ei, nf, nb);
        checks++;
        if (n !== 641 || nb !== 0) begin
            errors++; $display("FAIL wrap_count: got xfers=%0d badpix=%0d expected 641,0", n, nb);
        end
        checks++;
        if (ne !== 1 || ei !== 640 || nf !== 0) begin
            errors++;
            $display("FAIL wrap_eol: got eol_cnt=%0d eol_at=%0d eof_cnt=%0d expected 1,640,0", ne, ei, nf);
        end
        checks++;
        if (int'(dut.r_x) !== 1 || int'(dut.r_y) !== 1) begin
            errors++; $display("FAIL wrap_pos: got x=%0d y=%0d expected 1,1", dut.r_x, dut.r_y);
        end
    endtask

    task automatic test_zero_len();
        int n, ne, ei, nf, nb;
        bus.tok_pixel = 1'b1; bus.tok_len = 10'd0; bus.tok_valid = 1'b1;
        #1;
        checks++;
        if (bus.tok_ready !== 1'b1) begin
            errors++; $display("FAIL zero_tok_ready: got %0d expected 1", bus.tok_ready);
        end
        tick();
        bus.tok_valid = 1'b0;
        #1;
        checks++;
        if (bus.err_zero_len !== 1'b1 || bus.pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: got ezl=%0d valid=%0d expected 1,0", bus.err_zero_len, bus.pix_valid);
        end
        tick();
        checks++;
        if (bus.err_zero_len !== 1'b0 || bus.pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: got ezl=%0d valid=%0d expected 0,0", bus.err_zero_len, bus.pix_valid);
        end
        run_token(1'b0, 4, n, ne, ei, nf, nb);
        checks++;
        if (n !== 4 || nb !== 0 || ne !== 0) begin
            errors++;
            $display("FAIL zero_next_token: got xfers=%0d badpix=%0d eol=%0d expected 4,0,0", n, nb, ne);
        end
    endtask

    task automatic test_overrun();
        int n, ne, ei, nf, nb;
        pulse_new_im();
        run_token(1'b0, 1023, n, ne, ei, nf, nb);
        run_token(1'b0, 1023, n, ne, ei, nf, nb);
        run_token(1'b0, 510, n, ne, ei, nf, nb);
        checks++;
        if (int'(dut.r_x) !== 636 || int'(dut.r_y) !== IMG_H - 1) begin
            errors++;
            $display("FAIL ovr_setup_pos: got x=%0d y=%0d expected 636,%0d", dut.r_x, dut.r_y, IMG_H - 1);
        end
        bus.tok_pixel = 1'b1; bus.tok_len = 10'd10; bus.tok_valid = 1'b1; bus.pix_ready = 1'b1;
        #1;
        tick();
        bus.tok_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (bus.pix_valid !== 1'b1 || bus.pix_eof !== logic'(k == 4) || bus.tok_ready !== 1'b0) begin
                errors++;
                $display("FAIL ovr_xfer[%0d]: got valid=%0d eof=%0d tok_ready=%0d expected 1,%0d,0",
                         k, bus.pix_valid, bus.pix_eof, bus.tok_ready, (k == 4));
            end
            tick();
        end
        #1;
        checks++;
        if (bus.err_overrun !== 1'b1 || bus.pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_pulse: got eov=%0d valid=%0d expected 1,0", bus.err_overrun, bus.pix_valid);
        end
        checks++;
        if (int'(dut.r_x) !== 0 || int'(dut.r_y) !== 0) begin
            errors++; $display("FAIL ovr_pos: got x=%0d y=%0d expected 0,0", dut.r_x, dut.r_y);
        end
        tick();
        checks++;
        if (bus.err_overrun !== 1'b0 || bus.pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_after: got eov=%0d valid=%0d expected 0,0", bus.err_overrun, bus.pix_valid);
        end
    endtask

    task automatic test_new_im_and_async_reset();
        bus.tok_pixel = 1'b1; bus.tok_len = 10'd100; bus.tok_valid = 1'b1; bus.pix_ready = 1'b1;
        #1;
        tick();
        bus.tok_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #1;
        checks++;
        if (int'(dut.r_x) !== 20 || int'(dut.r_remaining) !== 80) begin
            errors++;
            $display("FAIL newim_setup: got x=%0d rem=%0d expected 20,80", dut.r_x, dut.r_remaining);
        end
        bus.tok_pixel = 1'b0; bus.tok_len = 10'd7; bus.tok_valid = 1'b1;
        pulse_new_im();
        bus.tok_valid = 1'b0;
        #1;
        checks++;
        if (bus.pix_valid !== 1'b0 || int'(dut.r_x) !== 0 || int'(dut.r_remaining) !== 0) begin
            errors++;
            $display("FAIL newim_state: got valid=%0d x=%0d rem=%0d expected 0,0,0",
                     bus.pix_valid, dut.r_x, dut.r_remaining);
        end
        checks++;
        if (bus.err_zero_len !== 1'b0 || bus.err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL newim_err: got ezl=%0d eov=%0d expected 0,0", bus.err_zero_len, bus.err_overrun);
        end
        bus.tok_pixel = 1'b1; bus.tok_len = 10'd5; bus.tok_valid = 1'b1;
        tick();
        bus.tok_valid = 1'b0;
        #1;
        checks++;
        if (bus.pix_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got valid=%0d expected 1", bus.pix_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.pix_valid !== 1'b0 || bus.tok_ready !== 1'b0 || bus.pix_out !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: got valid=%0d tok_ready=%0d pix=%0d expected 0,0,0",
                     bus.pix_valid, bus.tok_ready, bus.pix_out);
        end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_line_wrap();
        test_zero_len();
        test_overrun();
        test_new_im_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
